// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the sequencer's CPU-side and debug-side signals.
//
// Signals (named from the sequencer's point of view):
//   run, step, halt_req      debug control (level, pulse, pulse)
//   instr, zr, ng, a_reg     current instruction, ALU flags, jump target
//   pc_val                   PC register output fed back
//   bp_addr, bp_valid        breakpoint address and enable
//   pc_reset/load/inc, pc_in PC register controls and load value
//   exec_en                  one-cycle register/memory write strobe
//   halted, state, bp_hit    debug status
//
// Modports:
//   master - the sequencer itself.
//   slave  - the surrounding CPU / debug host.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             run;
    logic             step;
    logic             halt_req;
    logic [WIDTH-1:0] instr;
    logic             zr;
    logic             ng;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] pc_val;
    logic [WIDTH-1:0] bp_addr;
    logic             bp_valid;
    logic             pc_reset;
    logic             pc_load;
    logic             pc_inc;
    logic [WIDTH-1:0] pc_in;
    logic             exec_en;
    logic             halted;
    logic [1:0]       state;
    logic             bp_hit;

    modport master (
        input  run, step, halt_req, instr, zr, ng, a_reg, pc_val, bp_addr, bp_valid,
        output pc_reset, pc_load, pc_inc, pc_in, exec_en, halted, state, bp_hit
    );

    modport slave (
        output run, step, halt_req, instr, zr, ng, a_reg, pc_val, bp_addr, bp_valid,
        input  pc_reset, pc_load, pc_inc, pc_in, exec_en, halted, state, bp_hit
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-cycle controller for the Hack program counter.
//
// Steps each instruction through FETCH (FETCH_WAIT+1 cycles of ROM latency)
// and EXEC (one cycle, exec_en strobe, PC load/increment), with run/halt/step
// debug control. State encoding on bus.state: RST=00 FETCH=01 EXEC=10 HALT=11.
//
// Parameters:
//   WIDTH      data/address width (instr[15] is the C-instruction bit)
//   FETCH_WAIT ROM latency in cycles, legal range 0..7
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pc_sequencer_if master modport (see interface header)
//
// Optional feature: define PC_SEQ_BREAKPOINT_EN to enable the address
// breakpoint. Without it bp_hit is tied low and bp_addr/bp_valid are unused.
module pc_sequencer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FETCH_WAIT = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        StRst   = 2'b00,
        StFetch = 2'b01,
        StExec  = 2'b10,
        StHalt  = 2'b11
    } state_e;

    localparam logic [2:0] WaitLast = 3'(FETCH_WAIT);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       halt_pend_q, halt_pend_d;
    logic       step_q, step_d;
    logic       skip_bp_q, skip_bp_d;  // first FETCH after HALT must not re-trap
    logic       bp_hit_q, bp_hit_d;
    logic       jump;
    logic       bp_match;

    assign jump = bus.instr[15] & ((bus.instr[2] & bus.ng) |
                                   (bus.instr[1] & bus.zr) |
                                   (bus.instr[0] & ~bus.ng & ~bus.zr));

`ifdef PC_SEQ_BREAKPOINT_EN
    // Compare only on the first FETCH cycle, before any EXEC at this address.
    assign bp_match   = bus.bp_valid && (bus.pc_val == bus.bp_addr) &&
                        !skip_bp_q && (cnt_q == 3'd0);
    assign bus.bp_hit = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp  = ^{bus.bp_addr, bus.bp_valid, bus.pc_val, skip_bp_q, bp_hit_q};
    assign bp_match   = 1'b0;
    assign bus.bp_hit = 1'b0;
`endif

    assign bus.state = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRst;
            cnt_q       <= 3'd0;
            halt_pend_q <= 1'b0;
            step_q      <= 1'b0;
            skip_bp_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            step_q      <= step_d;
            skip_bp_q   <= skip_bp_d;
            bp_hit_q    <= bp_hit_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        halt_pend_d  = halt_pend_q;
        step_d       = step_q;
        skip_bp_d    = skip_bp_q;
        bp_hit_d     = bp_hit_q;
        bus.pc_reset = 1'b0;
        bus.pc_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_in    = '0;
        bus.exec_en  = 1'b0;
        bus.halted   = 1'b0;

        unique case (state_q)
            StRst: begin
                bus.pc_reset = 1'b1;
                state_d      = StFetch;
                cnt_d        = 3'd0;
                halt_pend_d  = 1'b0;
                step_d       = 1'b0;
                skip_bp_d    = 1'b0;
                bp_hit_d     = 1'b0;
            end

            StFetch: begin
                if (bus.halt_req) begin
                    halt_pend_d = 1'b1;
                end
                // Only the first FETCH cycle compares, so the skip can drop here.
                skip_bp_d = 1'b0;
                if (bp_match) begin
                    state_d     = StHalt;
                    bp_hit_d    = 1'b1;
                    cnt_d       = 3'd0;
                    halt_pend_d = 1'b0;
                    step_d      = 1'b0;
                end else if (cnt_q == WaitLast) begin
                    state_d = StExec;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            StExec: begin
                bus.exec_en = 1'b1;
                bus.pc_load = jump;
                bus.pc_inc  = ~jump;
                bus.pc_in   = bus.a_reg;
                step_d      = 1'b0;
                // A halt_req arriving in EXEC still lets this instruction finish.
                if (halt_pend_q || bus.halt_req || !bus.run || step_q) begin
                    state_d     = StHalt;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = StFetch;
                end
            end

            StHalt: begin
                bus.halted = 1'b1;
                // Already halted: a request here is satisfied, not queued.
                halt_pend_d = 1'b0;
                if (bus.halt_req) begin
                    state_d = StHalt;
                end else if (bus.step) begin
                    state_d   = StFetch;
                    step_d    = 1'b1;
                    skip_bp_d = 1'b1;
                    bp_hit_d  = 1'b0;
                    cnt_d     = 3'd0;
                end else if (bus.run) begin
                    state_d   = StFetch;
                    step_d    = 1'b0;
                    skip_bp_d = 1'b1;
                    bp_hit_d  = 1'b0;
                    cnt_d     = 3'd0;
                end
            end

            default: begin
                state_d = StRst;
            end
        endcase
    end

endmodule
